// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the RegFile access controller:
// register geometry, dump FSM states, requester ids and write payload.
package rf_ctrl_pkg;

    localparam int unsigned NREG  = 32;
    localparam int unsigned ADDRW = 5;
    localparam int unsigned DATAW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } dump_state_e;

    // Requester ids, also used as bit positions in req/gnt vectors.
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_access_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; LAST names the most recently granted requester
// and loses the next tie. Grants are combinational, LAST moves only on a grant.
module rr_arb2
    import rf_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       freeze,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (!freeze) begin
            if (req[REQ_A] && req[REQ_B]) begin
                if (last_q == REQ_B) gnt[REQ_A] = 1'b1;
                else                 gnt[REQ_B] = 1'b1;
            end else begin
                gnt = req;
            end
        end
    end

    // A grant is only ever raised for an active request, so gnt alone marks completion.
    always_ff @(posedge clk) begin
        if (rst)              last_q <= REQ_B;
        else if (gnt[REQ_A])  last_q <= REQ_A;
        else if (gnt[REQ_B])  last_q <= REQ_B;
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// RegFile side controller: round-robin write-port arbitration between ALU and
// load writeback, plus a sequencer that streams x0..x31 over the debug read port.
module regfile_access_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter bit DUMP_FREEZE = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             A_REQ,
    input  logic [ADDRW-1:0] A_ADDR,
    input  logic [DATAW-1:0] A_DATA,
    output logic             A_GNT,
    input  logic             B_REQ,
    input  logic [ADDRW-1:0] B_ADDR,
    input  logic [DATAW-1:0] B_DATA,
    output logic             B_GNT,
    output logic             RF_WE,
    output logic [ADDRW-1:0] RF_AW,
    output logic [DATAW-1:0] RF_D,
    output logic [ADDRW-1:0] RF_DBR,
    input  logic [DATAW-1:0] RF_DBO,
    input  logic             DUMP_START,
    output logic             DUMP_BUSY,
    output logic             DUMP_VALID,
    output logic [ADDRW-1:0] DUMP_ADDR,
    output logic [DATAW-1:0] DUMP_DATA,
    output logic             DUMP_DONE
);

    localparam logic [ADDRW-1:0] LAST_IDX = ADDRW'(NREG - 1);

    dump_state_e      state_q, state_d;
    logic [ADDRW-1:0] cnt_q, cnt_d;
    logic             iss_v_q;
    logic [ADDRW-1:0] iss_a_q;
    logic             busy;
    logic             freeze;
    logic [1:0]       req, gnt;
    logic             a_fire, b_fire;
    wr_req_t          a_wr, b_wr, wr_sel;

    assign busy = (state_q != IDLE);

    // Reset releases the freeze so grants follow requests while reset is held.
    assign freeze = DUMP_FREEZE && busy && !RST;

    assign req[REQ_A] = A_REQ;
    assign req[REQ_B] = B_REQ;

    rr_arb2 u_arb (
        .clk    (CLK),
        .rst    (RST),
        .req    (req),
        .freeze (freeze),
        .gnt    (gnt)
    );

    assign A_GNT  = gnt[REQ_A];
    assign B_GNT  = gnt[REQ_B];
    assign a_fire = A_REQ & A_GNT;
    assign b_fire = B_REQ & B_GNT;

    assign a_wr = '{addr: A_ADDR, data: A_DATA};
    assign b_wr = '{addr: B_ADDR, data: B_DATA};

    // Write port mux; idle port drives zeros.
    always_comb begin
        wr_sel = '0;
        if (a_fire)      wr_sel = a_wr;
        else if (b_fire) wr_sel = b_wr;
    end

    assign RF_WE = a_fire | b_fire;
    assign RF_AW = wr_sel.addr;
    assign RF_D  = wr_sel.data;

    // Dump sequencer: next state and debug read address.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        RF_DBR  = '0;
        case (state_q)
            IDLE: begin
                if (DUMP_START) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                RF_DBR = cnt_q;
                if (cnt_q == LAST_IDX) state_d = DRAIN;
                else                   cnt_d   = cnt_q + ADDRW'(1);
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ISS_V/ISS_A track the RegFile's one-cycle read latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            iss_v_q <= 1'b0;
            iss_a_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iss_v_q <= (state_q == ISSUE);
            iss_a_q <= cnt_q;
        end
    end

    assign DUMP_BUSY  = busy;
    assign DUMP_VALID = iss_v_q;
    assign DUMP_ADDR  = iss_a_q;
    assign DUMP_DATA  = iss_v_q ? RF_DBO : '0;
    assign DUMP_DONE  = iss_v_q && (iss_a_q == LAST_IDX);

endmodule
